// File: rtl/scrambler_pkg.sv
// Shared constants and FSM encoding for the scramble checker.
package scrambler_pkg;

    localparam int unsigned CHALL_W = 8;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned ERR_W   = 8;
    localparam int unsigned STEP_W  = 16;

    // Feedback taps of the step function: bits 0, 1, 2, 3 and 7
    localparam logic [CHALL_W-1:0] TAP_MASK = 8'b1000_1111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HUNT   = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

endpackage

// File: rtl/scrambler_step.sv
// Combinational scrambler step: f(c) = c ^ {parity(c & taps), c[7:1]}.
module scrambler_step
    import scrambler_pkg::*;
(
    input  logic [CHALL_W-1:0] c_i,
    output logic [CHALL_W-1:0] f_o
);

    logic fb;

    // Feedback bit is the parity of the tapped bits
    always_comb begin
        fb  = ^(c_i & TAP_MASK);
        f_o = c_i ^ {fb, c_i[CHALL_W-1:1]};
    end

endmodule

// File: rtl/scramble_checker.sv
// Scrambled-challenge checker: predicts the next challenge, hunts for lock,
// flywheels through isolated errors and counts mismatches while locked.
module scramble_checker
    import scrambler_pkg::*;
#(
    parameter int unsigned LOCK_CNT   = 3,
    parameter int unsigned UNLOCK_CNT = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               seed_valid,
    input  logic [CHALL_W-1:0] seed,
    input  logic               chall_valid,
    input  logic [CHALL_W-1:0] chall_in,
    output logic [CHALL_W-1:0] expected,
    output logic               locked,
    output logic               mismatch,
    output logic [ERR_W-1:0]   err_count,
    output logic [STEP_W-1:0]  step_count
);

    state_e              state_q, state_d;
    logic [CHALL_W-1:0]  expected_q, expected_d;
    logic [CHALL_W-1:0]  step_in, step_out;
    logic [CNT_W-1:0]    good_q, good_d;
    logic [CNT_W-1:0]    bad_q, bad_d;
    logic [ERR_W-1:0]    err_q, err_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic                mismatch_q, mismatch_d;
    logic                locked_q, locked_d;

    logic accept;
    logic differ;
    logic lock_hit;
    logic unlock_hit;

    // Beat qualification; a simultaneous seed always wins over the challenge
    assign accept     = chall_valid && !seed_valid && (state_q != ST_IDLE);
    assign differ     = (chall_in != expected_q);
    assign lock_hit   = (good_q + CNT_W'(1)) == CNT_W'(LOCK_CNT);
    assign unlock_hit = (bad_q + CNT_W'(1)) == CNT_W'(UNLOCK_CNT);

    // Scrambler operand: new seed, resync to the received value, or free-run
    always_comb begin
        step_in = expected_q;
        if (seed_valid) begin
            step_in = seed;
        end else if (accept && differ && ((state_q == ST_HUNT) || unlock_hit)) begin
            step_in = chall_in;
        end
    end

    scrambler_step u_step (
        .c_i (step_in),
        .f_o (step_out)
    );

    // Next-state and counter logic
    always_comb begin
        state_d    = state_q;
        expected_d = expected_q;
        good_d     = good_q;
        bad_d      = bad_q;
        err_d      = err_q;
        step_d     = step_q;
        mismatch_d = 1'b0;
        locked_d   = 1'b0;

        if (seed_valid) begin
            state_d    = ST_HUNT;
            expected_d = step_out;
            good_d     = '0;
            bad_d      = '0;
            step_d     = '0;
        end else if (accept) begin
            expected_d = step_out;
            step_d     = step_q + STEP_W'(1);
            mismatch_d = differ;
            case (state_q)
                ST_HUNT: begin
                    if (!differ) begin
                        if (lock_hit) begin
                            state_d = ST_LOCKED;
                            good_d  = '0;
                        end else begin
                            good_d = good_q + CNT_W'(1);
                        end
                    end else begin
                        good_d = '0;
                    end
                end
                ST_LOCKED: begin
                    if (!differ) begin
                        bad_d = '0;
                    end else begin
                        err_d = (err_q == {ERR_W{1'b1}}) ? err_q : err_q + ERR_W'(1);
                        if (unlock_hit) begin
                            state_d = ST_HUNT;
                            bad_d   = '0;
                        end else begin
                            bad_d = bad_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end

        locked_d = (state_d == ST_LOCKED);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            expected_q <= '0;
            good_q     <= '0;
            bad_q      <= '0;
            err_q      <= '0;
            step_q     <= '0;
            mismatch_q <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            expected_q <= expected_d;
            good_q     <= good_d;
            bad_q      <= bad_d;
            err_q      <= err_d;
            step_q     <= step_d;
            mismatch_q <= mismatch_d;
            locked_q   <= locked_d;
        end
    end

    assign expected   = expected_q;
    assign locked     = locked_q;
    assign mismatch   = mismatch_q;
    assign err_count  = err_q;
    assign step_count = step_q;

endmodule

// File: tb/tb_scramble_checker.sv
// Scoreboard bench for scramble_checker: the driver queues hand-computed
// expectations, the monitor pops and compares one edge later.
module tb_scramble_checker;

    typedef struct packed {
        logic [7:0]  expected;
        logic        locked;
        logic        mismatch;
        logic [7:0]  err;
        logic [15:0] step;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        seed_valid = 1'b0;
    logic [7:0]  seed = 8'h00;
    logic        chall_valid = 1'b0;
    logic [7:0]  chall_in = 8'h00;
    logic [7:0]  expected;
    logic        locked;
    logic        mismatch;
    logic [7:0]  err_count;
    logic [15:0] step_count;

    logic        chk = 1'b0;
    exp_t        exp_q[$];
    string       name_q[$];
    int          vectors = 0;
    int          miscompares = 0;

    scramble_checker #(
        .LOCK_CNT   (3),
        .UNLOCK_CNT (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .seed_valid  (seed_valid),
        .seed        (seed),
        .chall_valid (chall_valid),
        .chall_in    (chall_in),
        .expected    (expected),
        .locked      (locked),
        .mismatch    (mismatch),
        .err_count   (err_count),
        .step_count  (step_count)
    );

    always #5 clk = ~clk;

    // Drive one beat at the falling edge; queue its expectation when checked
    task automatic beat(input string n, input logic r, input logic sv, input logic [7:0] sd,
                        input logic cv, input logic [7:0] ci, input logic c,
                        input logic [7:0] e_exp, input logic e_lk, input logic e_mm,
                        input logic [7:0] e_err, input logic [15:0] e_step);
        exp_t e;
        @(negedge clk);
        rst         = r;
        seed_valid  = sv;
        seed        = sd;
        chall_valid = cv;
        chall_in    = ci;
        chk         = c;
        if (c) begin
            e = exp_t'({e_exp, e_lk, e_mm, e_err, e_step});
            exp_q.push_back(e);
            name_q.push_back(n);
        end
    endtask

    task automatic chal(input string n, input logic [7:0] ci, input logic [7:0] e_exp,
                        input logic e_lk, input logic e_mm, input logic [7:0] e_err,
                        input logic [15:0] e_step);
        beat(n, 1'b0, 1'b0, 8'h00, 1'b1, ci, 1'b1, e_exp, e_lk, e_mm, e_err, e_step);
    endtask

    task automatic sd(input string n, input logic [7:0] s, input logic [7:0] e_exp,
                      input logic [7:0] e_err);
        beat(n, 1'b0, 1'b1, s, 1'b0, 8'h00, 1'b1, e_exp, 1'b0, 1'b0, e_err, 16'h0000);
    endtask

    // Monitor: compare every checked beat one delta after the rising edge
    initial begin
        exp_t  e;
        exp_t  got;
        string n;
        forever begin
            @(posedge clk);
            if (chk) begin
                #1;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL scoreboard: checked beat with empty queue at %0t", $time);
                end else begin
                    e   = exp_q.pop_front();
                    n   = name_q.pop_front();
                    got = exp_t'({expected, locked, mismatch, err_count, step_count});
                    if (got !== e) begin
                        miscompares++;
                        $display("FAIL %s: got exp=%02h lock=%0b mm=%0b err=%02h step=%04h, need exp=%02h lock=%0b mm=%0b err=%02h step=%04h",
                                 n, got.expected, got.locked, got.mismatch, got.err, got.step,
                                 e.expected, e.locked, e.mismatch, e.err, e.step);
                    end
                end
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    // Directed stimulus
    initial begin
        int unsigned err_exp;
        beat("reset", 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 16'h0000);
        chal("idle_chall_ignored", 8'h55, 8'h00, 1'b0, 1'b0, 8'h00, 16'h0000);

        // Lock on seed 0xD4: BE, E1, 91 -> next D9
        sd("seed_d4", 8'hD4, 8'hBE, 8'h00);
        chal("hunt_be", 8'hBE, 8'hE1, 1'b0, 1'b0, 8'h00, 16'h0001);
        chal("hunt_e1", 8'hE1, 8'h91, 1'b0, 1'b0, 8'h00, 16'h0002);
        chal("lock_91", 8'h91, 8'hD9, 1'b1, 1'b0, 8'h00, 16'h0003);

        // Single corrupted beat: flywheel D9 -> 35, stays locked
        chal("lk_bad1", 8'h00, 8'h35, 1'b1, 1'b1, 8'h01, 16'h0004);
        chal("lk_good", 8'h35, 8'h2F, 1'b1, 1'b0, 8'h01, 16'h0005);
        beat("idle_mm_clear", 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h2F, 1'b1, 1'b0, 8'h01, 16'h0005);

        // Two consecutive bad beats: unlock, resync to f(0x01)=0x81
        chal("lk_bad_a", 8'h00, 8'h38, 1'b1, 1'b1, 8'h02, 16'h0006);
        chal("lk_bad_b", 8'h01, 8'h81, 1'b0, 1'b1, 8'h03, 16'h0007);

        // Hunt mismatch resyncs to f(0x00)=0x00, err_count untouched
        sd("reseed_d4", 8'hD4, 8'hBE, 8'h03);
        chal("hunt_resync", 8'h00, 8'h00, 1'b0, 1'b1, 8'h03, 16'h0001);

        // Seed and challenge together: seed wins
        beat("seed_wins", 1'b0, 1'b1, 8'hD4, 1'b1, 8'h12, 1'b1, 8'hBE, 1'b0, 1'b0, 8'h03, 16'h0000);
        chal("relock_be", 8'hBE, 8'hE1, 1'b0, 1'b0, 8'h03, 16'h0001);
        chal("relock_e1", 8'hE1, 8'h91, 1'b0, 1'b0, 8'h03, 16'h0002);
        chal("relock_91", 8'h91, 8'hD9, 1'b1, 1'b0, 8'h03, 16'h0003);

        // Reset mid-LOCKED, then challenges ignored in IDLE
        beat("rst_mid_lock", 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 16'h0000);
        chal("post_rst_ignored", 8'hD9, 8'h00, 1'b0, 1'b0, 8'h00, 16'h0000);

        // Seed 0x00: constant-zero sequence, then drive err_count to saturation
        sd("seed_00", 8'h00, 8'h00, 8'h00);
        chal("z_hunt1", 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 16'h0001);
        chal("z_hunt2", 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 16'h0002);
        chal("z_lock", 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 16'h0003);
        for (int k = 1; k <= 300; k++) begin
            err_exp = (k > 255) ? 255 : k;
            chal("sat_bad", 8'hFF, 8'h00, 1'b1, 1'b1, 8'(err_exp), 16'(3 + 2 * k - 1));
            chal("sat_good", 8'h00, 8'h00, 1'b1, 1'b0, 8'(err_exp), 16'(3 + 2 * k));
        end

        beat("drain", 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 16'h0000);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left unchecked, need 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
